// File: rtl/gpio_pkg.sv
// Shared definitions for the iomem GPIO bank.
// Holds the word offsets of the register map (iomem_addr[7:2]), the default
// block select value for iomem_addr[31:24], and a byte-lane mask helper.
package gpio_pkg;

  localparam logic [7:0] GPIO_BASE_ADDR = 8'h03;

  localparam logic [5:0] GPIO_OFS_OUT  = 6'h00;
  localparam logic [5:0] GPIO_OFS_DIR  = 6'h01;
  localparam logic [5:0] GPIO_OFS_IN   = 6'h02;
  localparam logic [5:0] GPIO_OFS_MASK = 6'h03;
  localparam logic [5:0] GPIO_OFS_EDGE = 6'h04;
  localparam logic [5:0] GPIO_OFS_PEND = 6'h05;
  localparam logic [5:0] GPIO_OFS_SET  = 6'h06;
  localparam logic [5:0] GPIO_OFS_CLR  = 6'h07;
  localparam logic [5:0] GPIO_OFS_TGL  = 6'h08;

  // Expand the 4 byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] gpio_lane_mask(input logic [3:0] wstrb);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{wstrb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser and edge detector for one GPIO bank.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   din         - asynchronous pad inputs
//   edge_rise   - per-pin edge select, 1 = rising, 0 = falling
//   sync        - synchronised input value (STAGES cycles of latency)
//   evt         - one-cycle per-pin edge event
module gpio_sync_edge #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] edge_rise,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] evt
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    sync_d[0] = din;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[STAGES-1];
  assign evt  = (edge_rise & sync & ~prev_q) | (~edge_rise & ~sync & prev_q);

endmodule

// File: rtl/iomem_gpio_bank.sv
// GPIO peripheral for the picosoc iomem bus: output, direction, synchronised
// input readback and per-pin edge interrupts with mask and W1C pending.
// Optional macro GPIO_ATOMIC_EN adds write-only SET/CLR/TGL aliases of OUT.
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   iomem_valid/ready    - request / one-cycle acknowledge
//   iomem_wstrb          - byte write strobes, 0 = read
//   iomem_addr/wdata     - byte address / write data
//   iomem_rdata          - read data, valid while iomem_ready=1
//   gpio_out, gpio_oe    - pad output value and enable (1 = drive)
//   gpio_in              - asynchronous pad inputs
//   irq                  - level interrupt, |(PEND & MASK) registered
module iomem_gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH  = 32,
  parameter logic [7:0]  BASE_ADDR   = GPIO_BASE_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  irq
);

  localparam int unsigned W = GPIO_WIDTH;

`ifdef GPIO_ATOMIC_EN
  localparam bit ATOMIC_EN = 1'b1;
`else
  localparam bit ATOMIC_EN = 1'b0;
`endif

  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [W-1:0]  out_q, out_d;
  logic [W-1:0]  dir_q, dir_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [W-1:0]  edge_q, edge_d;
  logic [W-1:0]  pend_q, pend_d;
  logic          irq_q, irq_d;
  logic [W-1:0]  sync_w, evt_w;

  logic          sel, wr;
  logic [5:0]    ofs;
  logic [31:0]   bmask;
  logic [W-1:0]  wbits;
  logic          addr_unused;

  assign sel         = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
  assign wr          = sel && (iomem_wstrb != 4'b0000);
  assign ofs         = iomem_addr[7:2];
  assign bmask       = gpio_lane_mask(iomem_wstrb);
  assign wbits       = W'(iomem_wdata & bmask);
  assign addr_unused = ^{iomem_addr[23:8], iomem_addr[1:0]};

  gpio_sync_edge #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .din       (gpio_in),
    .edge_rise (edge_q),
    .sync      (sync_w),
    .evt       (evt_w)
  );

  // Byte-lane merge of write data into an RW register.
  function automatic logic [W-1:0] lane_merge(input logic [W-1:0] old,
                                              input logic [31:0]  wd,
                                              input logic [31:0]  m);
    return W'((32'(old) & ~m) | (wd & m));
  endfunction

  always_comb begin
    ready_d = sel;
    rdata_d = '0;
    out_d   = out_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    edge_d  = edge_q;
    irq_d   = |(pend_q & mask_q);

    // Read returns the pre-write value of the addressed register.
    if (sel) begin
      case (ofs)
        GPIO_OFS_OUT:  rdata_d = 32'(out_q);
        GPIO_OFS_DIR:  rdata_d = 32'(dir_q);
        GPIO_OFS_IN:   rdata_d = 32'(sync_w);
        GPIO_OFS_MASK: rdata_d = 32'(mask_q);
        GPIO_OFS_EDGE: rdata_d = 32'(edge_q);
        GPIO_OFS_PEND: rdata_d = 32'(pend_q);
        default:       rdata_d = '0;
      endcase
    end

    if (wr) begin
      case (ofs)
        GPIO_OFS_OUT:  out_d  = lane_merge(out_q,  iomem_wdata, bmask);
        GPIO_OFS_DIR:  dir_d  = lane_merge(dir_q,  iomem_wdata, bmask);
        GPIO_OFS_MASK: mask_d = lane_merge(mask_q, iomem_wdata, bmask);
        GPIO_OFS_EDGE: edge_d = lane_merge(edge_q, iomem_wdata, bmask);
        GPIO_OFS_SET:  if (ATOMIC_EN) out_d = out_q | wbits;
        GPIO_OFS_CLR:  if (ATOMIC_EN) out_d = out_q & ~wbits;
        GPIO_OFS_TGL:  if (ATOMIC_EN) out_d = out_q ^ wbits;
        default:       ;
      endcase
    end

    // Clear first, then OR in new events so a coincident event survives.
    pend_d = pend_q;
    if (wr && (ofs == GPIO_OFS_PEND)) begin
      pend_d = pend_q & ~wbits;
    end
    pend_d = pend_d | evt_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      dir_q   <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Self-checking bench for iomem_gpio_bank: a 32-pin and an 8-pin instance
// share the bus inputs; a vector table drives register traffic, followed by
// hand-written edge/interrupt and address-window sequences.
module tb_iomem_gpio_bank;

`ifdef GPIO_ATOMIC_EN
  localparam logic [31:0] EXP_SET = 32'h0000_00FF;
  localparam logic [31:0] EXP_CLR = 32'h0000_00FC;
  localparam logic [31:0] EXP_TGL = 32'h0000_00F3;
`else
  localparam logic [31:0] EXP_SET = 32'h0000_000F;
  localparam logic [31:0] EXP_CLR = 32'h0000_000F;
  localparam logic [31:0] EXP_TGL = 32'h0000_000F;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] gpio_in;

  logic        ready, ready8;
  logic [31:0] rdata, rdata8;
  logic [31:0] gpio_out, gpio_oe;
  logic [7:0]  gpio_out8, gpio_oe8;
  logic        irq, irq8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  iomem_gpio_bank #(
    .GPIO_WIDTH  (32),
    .BASE_ADDR   (8'h03),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (rdata),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .gpio_in     (gpio_in),
    .irq         (irq)
  );

  iomem_gpio_bank #(
    .GPIO_WIDTH  (8),
    .BASE_ADDR   (8'h03),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (ready8),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (rdata8),
    .gpio_out    (gpio_out8),
    .gpio_oe     (gpio_oe8),
    .gpio_in     (gpio_in[7:0]),
    .irq         (irq8)
  );

  typedef struct {
    string       name;
    logic [3:0]  ws;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [31:0] exp8;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [3:0] ws, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] e, input logic [31:0] e8);
    vec_t v;
    v.name = nm; v.ws = ws; v.addr = a; v.wdata = wd; v.exp = e; v.exp8 = e8;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One bus transaction from just after a posedge; returns just after the
  // edge following the ack, having checked ack latency and width.
  task automatic bus(input logic [3:0] ws, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic [31:0] rd8);
    int unsigned cyc = 0;
    bit got = 0;
    logic r8 = 1'b0;
    rd  = '0;
    rd8 = '0;
    iomem_valid = 1'b1;
    iomem_wstrb = ws;
    iomem_addr  = a;
    iomem_wdata = wd;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin
        got = 1;
        rd  = rdata;
        rd8 = rdata8;
        r8  = ready8;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    check("ack_latency", 32'(cyc), 32'd1);
    check("ack8", 32'(r8), 32'd1);
    @(posedge clk); #1;
    check("ack_width", 32'(ready), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, rd8;
    int unsigned seen;

    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    gpio_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_out", gpio_out, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);

    add_vec("rd_out_rst",  4'h0, 32'h0300_0000, 32'h0,         32'h0,         32'h0);
    add_vec("rd_dir_rst",  4'h0, 32'h0300_0004, 32'h0,         32'h0,         32'h0);
    add_vec("rd_mask_rst", 4'h0, 32'h0300_000C, 32'h0,         32'h0,         32'h0);
    add_vec("rd_edge_rst", 4'h0, 32'h0300_0010, 32'h0,         32'h0,         32'h0);
    add_vec("rd_pend_rst", 4'h0, 32'h0300_0014, 32'h0,         32'h0,         32'h0);
    add_vec("wr_out_lo",   4'h3, 32'h0300_0000, 32'hA5A5_A5A5, 32'h0,         32'h0);
    add_vec("rd_out_lo",   4'h0, 32'h0300_0000, 32'h0,         32'h0000_A5A5, 32'h0000_00A5);
    add_vec("wr_dir",      4'hF, 32'h0300_0004, 32'h0000_00FF, 32'h0,         32'h0);
    add_vec("rd_dir",      4'h0, 32'h0300_0004, 32'h0,         32'h0000_00FF, 32'h0000_00FF);
    add_vec("wr_out_all",  4'hF, 32'h0300_0000, 32'hFFFF_FFFF, 32'h0000_A5A5, 32'h0000_00A5);
    add_vec("rd_out_all",  4'h0, 32'h0300_0000, 32'h0,         32'hFFFF_FFFF, 32'h0000_00FF);
    add_vec("wr_out_b2",   4'h4, 32'h0300_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_00FF);
    add_vec("rd_out_b2",   4'h0, 32'h0300_0000, 32'h0,         32'hFF34_FFFF, 32'h0000_00FF);
    add_vec("rd_unmapped", 4'h0, 32'h0300_0040, 32'h0,         32'h0,         32'h0);
    add_vec("wr_unmapped", 4'hF, 32'h0300_0040, 32'hFFFF_FFFF, 32'h0,         32'h0);
    add_vec("wr_in",       4'hF, 32'h0300_0008, 32'hFFFF_FFFF, 32'h0,         32'h0);
    add_vec("rd_in",       4'h0, 32'h0300_0008, 32'h0,         32'h0,         32'h0);
    add_vec("rd_out_kept", 4'h0, 32'h0300_0000, 32'h0,         32'hFF34_FFFF, 32'h0000_00FF);
    add_vec("wr_out_0f",   4'hF, 32'h0300_0000, 32'h0000_000F, 32'hFF34_FFFF, 32'h0000_00FF);
    add_vec("wr_set",      4'hF, 32'h0300_0018, 32'h0000_00F0, 32'h0,         32'h0);
    add_vec("rd_after_set",4'h0, 32'h0300_0000, 32'h0,         EXP_SET,       EXP_SET);
    add_vec("wr_clr",      4'hF, 32'h0300_001C, 32'h0000_0003, 32'h0,         32'h0);
    add_vec("rd_after_clr",4'h0, 32'h0300_0000, 32'h0,         EXP_CLR,       EXP_CLR);
    add_vec("wr_tgl",      4'hF, 32'h0300_0020, 32'h0000_000F, 32'h0,         32'h0);
    add_vec("rd_after_tgl",4'h0, 32'h0300_0000, 32'h0,         EXP_TGL,       EXP_TGL);

    foreach (vecs[i]) begin
      bus(vecs[i].ws, vecs[i].addr, vecs[i].wdata, rd, rd8);
      check(vecs[i].name, rd, vecs[i].exp);
      check({vecs[i].name, "_w8"}, rd8, vecs[i].exp8);
    end

    check("pad_oe", gpio_oe, 32'h0000_00FF);
    check("pad_out", gpio_out, EXP_TGL);
    check("pad_oe_w8", 32'(gpio_oe8), 32'h0000_00FF);
    check("pad_out_w8", 32'(gpio_out8), EXP_TGL);

    // Rising edge on pin 3, masked in: PEND set, irq one cycle later.
    bus(4'hF, 32'h0300_0010, 32'h0000_0008, rd, rd8);
    bus(4'hF, 32'h0300_000C, 32'h0000_0008, rd, rd8);
    gpio_in[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("irq_not_yet", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("irq_rise", 32'(irq), 32'd1);
    bus(4'h0, 32'h0300_0008, 32'h0, rd, rd8);
    check("rd_in_pin3", rd, 32'h0000_0008);
    bus(4'h0, 32'h0300_0014, 32'h0, rd, rd8);
    check("rd_pend_pin3", rd, 32'h0000_0008);
    bus(4'hF, 32'h0300_0014, 32'h0000_0008, rd, rd8);
    check("w1c_pend_pre", rd, 32'h0000_0008);
    check("irq_fall", 32'(irq), 32'd0);
    bus(4'h0, 32'h0300_0014, 32'h0, rd, rd8);
    check("rd_pend_clr", rd, 32'h0);

    // Pin 5 falling-edge mode, unmasked: rising is ignored, falling pends.
    gpio_in[5] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus(4'h0, 32'h0300_0014, 32'h0, rd, rd8);
    check("pend_no_rise5", rd, 32'h0);
    gpio_in[5] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus(4'h0, 32'h0300_0014, 32'h0, rd, rd8);
    check("pend_fall5", rd, 32'h0000_0020);
    check("irq_masked", 32'(irq), 32'd0);

    // New event on pin 5 lands on the same edge as its W1C: set wins.
    gpio_in[5] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    gpio_in[5] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus(4'hF, 32'h0300_0014, 32'h0000_0020, rd, rd8);
    bus(4'h0, 32'h0300_0014, 32'h0, rd, rd8);
    check("pend_set_wins", rd, 32'h0000_0020);
    bus(4'hF, 32'h0300_0014, 32'h0000_0020, rd, rd8);
    bus(4'h0, 32'h0300_0014, 32'h0, rd, rd8);
    check("pend_clr5", rd, 32'h0);

    // Outside the window: never acked.
    seen = 0;
    iomem_valid = 1'b1;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0400_0000;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready || ready8) seen++;
    end
    iomem_valid = 1'b0;
    check("no_ack_outside", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
